// File: rtl/uart_debug_ctrl_if.sv
// Byte-level link between the debug controller and the uart_rx/uart_tx units.
// master: the debug controller; slave: the UART side.
interface uart_debug_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done_tick;

  modport master (
    input  rx_data,
    input  rx_done_tick,
    input  tx_done_tick,
    output tx_data,
    output tx_start
  );

  modport slave (
    output rx_data,
    output rx_done_tick,
    output tx_done_tick,
    input  tx_data,
    input  tx_start
  );
endinterface

// File: rtl/uart_debug_ctrl.sv
// UART debug controller: single-byte run/pause/step commands drive the
// pipeline clock enable; 'd' snapshots the cycle counter and debug taps and
// streams them as HDR, count[4], words..., XOR checksum.
module uart_debug_ctrl #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_debug_ctrl_if.master             uart,
  input  logic [NUM_WORDS*WORD_W-1:0]   debug_bus,
  output logic                          clk_en,
  output logic                          busy,
  output logic [31:0]                   cycle_count
);

  localparam int unsigned PAY_W     = 32 + NUM_WORDS * WORD_W;
  localparam int unsigned PAY_BYTES = PAY_W / 8;
  // Packet indices: 0 = header, 1..PAY_BYTES = payload, PAY_BYTES+1 = checksum.
  localparam logic [11:0] LAST_IDX  = 12'(PAY_BYTES + 1);
  localparam logic [11:0] PRE_CSUM  = 12'(PAY_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_advance;
  logic               w_cmd_run;
  logic               w_cmd_pause;
  logic               w_cmd_step;
  logic               w_cmd_dump;
  logic [PAY_W-1:0]   w_payload;

  logic               r_clk_en;
  logic               r_step;
  logic [31:0]        r_cycle_count;
  logic [PAY_W-1:0]   r_snap;
  logic [11:0]        r_idx;
  logic [7:0]         r_csum;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;

  assign w_cmd_run   = uart.rx_done_tick && (uart.rx_data == 8'h73);
  assign w_cmd_pause = uart.rx_done_tick && (uart.rx_data == 8'h70);
  assign w_cmd_step  = uart.rx_done_tick && (uart.rx_data == 8'h74);
  assign w_cmd_dump  = uart.rx_done_tick && (uart.rx_data == 8'h64);

  // Payload image, MSB-first: cycle count, then word 0 .. word NUM_WORDS-1.
  always_comb begin
    w_payload = '0;
    w_payload[PAY_W-1 -: 32] = r_cycle_count;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      w_payload[PAY_W-33-k*WORD_W -: WORD_W] = debug_bus[k*WORD_W +: WORD_W];
    end
  end

  // Clock-enable control; a step holds clk_en high for one cycle only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_en <= 1'b0;
      r_step   <= 1'b0;
    end else if (w_cmd_run) begin
      r_clk_en <= 1'b1;
      r_step   <= 1'b0;
    end else if (w_cmd_pause) begin
      r_clk_en <= 1'b0;
      r_step   <= 1'b0;
    end else if (w_cmd_step && !r_clk_en) begin
      r_clk_en <= 1'b1;
      r_step   <= 1'b1;
    end else if (r_step) begin
      r_clk_en <= 1'b0;
      r_step   <= 1'b0;
    end
  end

  // Free-running count of enabled cycles, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (r_clk_en) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dump FSM next state; snapshot capture happens on the accepting edge so
  // the header goes out the very next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_dump) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (uart.tx_done_tick) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = ST_SEND;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Packet datapath: snapshot shifts out a byte per advance, checksum tracks it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_idx      <= '0;
      r_csum     <= '0;
      r_snap     <= '0;
    end else begin
      r_tx_start <= w_accept | w_advance;
      if (w_accept) begin
        r_snap    <= w_payload;
        r_idx     <= '0;
        r_csum    <= '0;
        r_tx_data <= HDR_BYTE;
      end else if (w_advance) begin
        r_idx <= r_idx + 12'd1;
        if (r_idx == PRE_CSUM) begin
          r_tx_data <= r_csum;
        end else begin
          r_tx_data <= r_snap[PAY_W-1 -: 8];
          r_csum    <= r_csum ^ r_snap[PAY_W-1 -: 8];
          r_snap    <= {r_snap[PAY_W-9:0], 8'h00};
        end
      end
    end
  end

  assign clk_en        = r_clk_en;
  assign cycle_count   = r_cycle_count;
  assign busy          = (r_state != ST_IDLE);
  assign uart.tx_data  = r_tx_data;
  assign uart.tx_start = r_tx_start;

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Directed bench for uart_debug_ctrl with WORD_W=32, NUM_WORDS=2.
// A UART-tx stand-in captures each byte on tx_start and answers with
// tx_done_tick five cycles later.
module tb_uart_debug_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] debug_bus;
  logic        clk_en;
  logic        busy;
  logic [31:0] cycle_count;

  uart_debug_ctrl_if u_if();

  uart_debug_ctrl #(
    .WORD_W    (32),
    .NUM_WORDS (2),
    .HDR_BYTE  (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart        (u_if),
    .debug_bus   (debug_bus),
    .clk_en      (clk_en),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  q[$];
  bit          resp_en = 1'b1;
  int          pulse_req = 0;

  logic [7:0] exp_a [14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB,
                             8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
  logic [7:0] exp_b [14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'h89, 8'hAB,
                             8'hCD, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h05};
  logic [7:0] exp_c [14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99, 8'hAA,
                             8'hBB, 8'hCC, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART-tx stand-in, acting on falling edges.
  initial begin
    int dly;
    int pulse_done;
    dly = 0;
    pulse_done = 0;
    u_if.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      u_if.tx_done_tick = 1'b0;
      if (pulse_req != pulse_done) begin
        u_if.tx_done_tick = 1'b1;
        pulse_done = pulse_req;
      end
      if (reset || !resp_en) begin
        dly = 0;
      end else begin
        if (dly > 0) begin
          dly--;
          if (dly == 0) u_if.tx_done_tick = 1'b1;
        end
        if (u_if.tx_start) begin
          q.push_back(u_if.tx_data);
          dly = 5;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    u_if.rx_data      = b;
    u_if.rx_done_tick = 1'b1;
    @(negedge clk);
    u_if.rx_done_tick = 1'b0;
    #1;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    for (int i = 0; i < 3000 && q.size() < n; i++) tick(1);
    check(tag, 64'(q.size()), 64'(n));
  endtask

  task automatic finish_dump(input string tag);
    wait_bytes(14, {tag, "_count"});
    for (int i = 0; i < 100 && u_if.tx_done_tick !== 1'b1; i++) tick(1);
    check({tag, "_busy_at_last_done"}, 64'(busy), 64'd1);
    tick(1);
    check({tag, "_busy_after_last_done"}, 64'(busy), 64'd0);
    tick(20);
    check({tag, "_no_extra_bytes"}, 64'(q.size()), 64'd14);
  endtask

  task automatic check_packet(input string tag, input logic [7:0] exp [14]);
    for (int i = 0; i < 14; i++) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < q.size()) ? 64'(q[i]) : 64'h100, 64'(exp[i]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    u_if.rx_data      = 8'h00;
    u_if.rx_done_tick = 1'b0;
    debug_bus         = 64'h11223344_AABBCCDD;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    tick(1);
    check("rst_clk_en", 64'(clk_en), 64'd0);
    check("rst_tx_start", 64'(u_if.tx_start), 64'd0);
    check("rst_tx_data", 64'(u_if.tx_data), 64'h00);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);

    // Non-command bytes and a stray tx_done_tick in IDLE.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h41);
    resp_en = 1'b0;
    pulse_req++;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("idle_no_tx_start", 64'(u_if.tx_start), 64'd0);
    end
    resp_en = 1'b1;
    check("idle_clk_en", 64'(clk_en), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_no_bytes", 64'(q.size()), 64'd0);

    // Basic dump, count 0.
    send_byte(8'h64);
    check("d1_first_start", 64'(u_if.tx_start), 64'd1);
    check("d1_first_data", 64'(u_if.tx_data), 64'hA5);
    check("d1_busy", 64'(busy), 64'd1);
    finish_dump("d1");
    check_packet("d1_byte", exp_a);

    // Run 10 cycles, then pause.
    send_byte(8'h73);
    check("run_clk_en", 64'(clk_en), 64'd1);
    tick(10);
    check("run_count10", 64'(cycle_count), 64'd10);
    send_byte(8'h70);
    check("pause_clk_en", 64'(clk_en), 64'd0);
    check("pause_count11", 64'(cycle_count), 64'd11);
    tick(5);
    check("pause_hold", 64'(cycle_count), 64'd11);

    // Single steps while paused.
    send_byte(8'h74);
    check("step1_hi", 64'(clk_en), 64'd1);
    tick(1);
    check("step1_lo", 64'(clk_en), 64'd0);
    check("step1_count", 64'(cycle_count), 64'd12);
    tick(20);
    send_byte(8'h74);
    check("step2_hi", 64'(clk_en), 64'd1);
    tick(1);
    check("step2_lo", 64'(clk_en), 64'd0);
    check("step2_count", 64'(cycle_count), 64'd13);

    // Step while running is ignored.
    send_byte(8'h73);
    send_byte(8'h74);
    check("run_step_ignored_a", 64'(clk_en), 64'd1);
    tick(3);
    check("run_step_ignored_b", 64'(clk_en), 64'd1);

    // Known count of 5, then a dump disturbed by commands and new taps.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    send_byte(8'h73);
    tick(4);
    send_byte(8'h70);
    check("pre_d2_count", 64'(cycle_count), 64'd5);
    debug_bus = 64'h01234567_89ABCDEF;
    q.delete();
    send_byte(8'h64);
    check("d2_first_start", 64'(u_if.tx_start), 64'd1);
    tick(3);
    send_byte(8'h64);
    send_byte(8'h73);
    check("d2_run_mid_dump", 64'(clk_en), 64'd1);
    debug_bus = 64'hDEADBEEF_CAFEF00D;
    finish_dump("d2");
    check_packet("d2_byte", exp_b);

    // Reset after the fifth byte aborts, then a fresh dump.
    debug_bus = 64'h55667788_99AABBCC;
    q.delete();
    send_byte(8'h64);
    wait_bytes(5, "d3_five_bytes");
    reset = 1'b1;
    tick(1);
    check("d3_rst_tx_start", 64'(u_if.tx_start), 64'd0);
    check("d3_rst_busy", 64'(busy), 64'd0);
    check("d3_rst_clk_en", 64'(clk_en), 64'd0);
    check("d3_rst_count", 64'(cycle_count), 64'd0);
    reset = 1'b0;
    tick(20);
    check("d3_no_tx_after_rst", 64'(q.size()), 64'd5);
    q.delete();
    send_byte(8'h64);
    check("d4_first_start", 64'(u_if.tx_start), 64'd1);
    check("d4_first_data", 64'(u_if.tx_data), 64'hA5);
    finish_dump("d4");
    check_packet("d4_byte", exp_c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
